// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M iterative divide unit: widths, op
// encodings, FSM states and small operand helpers.
package div_unit_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int CNT_W = 6;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic is_signed_op(input op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Magnitude of a two's-complement value; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                                input logic             is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                 input logic             neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left by one,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step
    import div_unit_pkg::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;

    // The trial difference is two bits wider than the remainder so the borrow
    // is never lost; a kept difference is always below the divisor.
    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        trial   = {1'b0, shifted} - {2'b00, divisor};
        if (trial[XLEN+1:XLEN] == 2'b00) begin
            rem_out = trial[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = shifted[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) whose registered writeback
// outputs drive the register file write port directly.
module div_unit
    import div_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [REG_W-1:0] rd,
    input  logic             flush,
    output logic             busy,
    output logic             wb_en,
    output logic [REG_W-1:0] wb_rd,
    output logic [XLEN-1:0]  wb_data
);

    state_e             state;
    logic [REG_W-1:0]   rd_q;
    logic               rem_sel_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic [XLEN-1:0]    quo_q;
    logic [XLEN-1:0]    rem_q;
    logic [XLEN-1:0]    divisor_q;
    logic [CNT_W-1:0]   count;
    logic               short_pend;
    logic [XLEN-1:0]    short_data;

    op_e                op_in;
    logic               op_signed;
    logic               op_rem;
    logic               div_zero;
    logic               overflow;
    logic [XLEN-1:0]    short_val;
    logic [XLEN-1:0]    step_rem;
    logic [XLEN-1:0]    step_quo;
    logic [XLEN-1:0]    fix_result;

    assign op_in     = op_e'(op);
    assign op_signed = is_signed_op(op_in);
    assign op_rem    = is_rem_op(op_in);
    assign div_zero  = (rs2_val == '0);
    assign overflow  = op_signed && (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);

    // Architecturally defined results that bypass the iteration entirely.
    always_comb begin
        short_val = '0;
        if (div_zero) begin
            short_val = op_rem ? rs1_val : '1;
        end else if (overflow) begin
            short_val = op_rem ? '0 : 32'h8000_0000;
        end
    end

    assign fix_result = rem_sel_q ? cond_neg(rem_q, neg_rem_q)
                                  : cond_neg(quo_q, neg_quo_q);

    div_step u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (divisor_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    assign busy = (state != ST_IDLE);

    // Control FSM. A short-path result is parked in short_data for one cycle
    // while the FSM stays idle, so a new start can be accepted alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rd_q       <= '0;
            rem_sel_q  <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            count      <= '0;
            short_pend <= 1'b0;
            short_data <= '0;
            wb_en      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
        end else begin
            wb_en <= 1'b0;
            if (flush) begin
                state      <= ST_IDLE;
                short_pend <= 1'b0;
            end else begin
                if (short_pend) begin
                    short_pend <= 1'b0;
                    if (rd_q != '0) begin
                        wb_en   <= 1'b1;
                        wb_rd   <= rd_q;
                        wb_data <= short_data;
                    end
                end
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            rd_q      <= rd;
                            rem_sel_q <= op_rem;
                            if (div_zero || overflow) begin
                                short_data <= short_val;
                                short_pend <= 1'b1;
                            end else begin
                                quo_q     <= abs_val(rs1_val, op_signed);
                                divisor_q <= abs_val(rs2_val, op_signed);
                                rem_q     <= '0;
                                neg_quo_q <= op_signed && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
                                neg_rem_q <= op_signed && rs1_val[XLEN-1];
                                count     <= '0;
                                state     <= ST_CALC;
                            end
                        end
                    end
                    ST_CALC: begin
                        quo_q <= step_quo;
                        rem_q <= step_rem;
                        count <= count + 1'b1;
                        if (count == LAST_STEP) begin
                            state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        if (rd_q != '0) begin
                            wb_en   <= 1'b1;
                            wb_rd   <= rd_q;
                            wb_data <= fix_result;
                        end
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divide unit sitting between register-file read ports and the writeback port. Accepts two 32-bit operands read from the register file plus a destination index, runs a 32-step restoring division, and presents the result with a write enable and destination index that drive the register file's write port directly. Handles DIV, DIVU, REM and REMU, including the RISC-V divide-by-zero and signed-overflow results.

## Interface
- No parameters; XLEN fixed at 32, 5-bit register index.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start.
- rs1_val  input  32  dividend; sampled with start.
- rs2_val  input  32  divisor; sampled with start.
- rd  input  5  destination register; sampled with start.
- flush  input  1  synchronous abort of the operation in flight.
- busy  output  1  operation in flight; start ignored while high.
- wb_en  output  1  one-cycle writeback strobe, drives enable_write.
- wb_rd  output  5  destination, drives r_write.
- wb_data  output  32  quotient or remainder, drives data_write.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: start=1 latches op, rd, |rs1|, |rs2| (absolute value only for DIV/REM), result-sign flags; clears remainder, count=0; goes to CALC.
- Short path from IDLE on start: divisor==0 -> quotient 0xFFFFFFFF, remainder rs1_val; signed op with rs1=0x80000000, rs2=0xFFFFFFFF -> quotient 0x80000000, remainder 0. Writeback issued next edge; state stays IDLE.
- CALC: one restoring step per edge: shift {rem,quo} left 1, trial-subtract divisor from 34-bit-safe remainder, keep if non-negative and set quotient LSB. count increments; after 32nd step go to FIX.
- FIX: negate quotient if sign(rs1)^sign(rs2) (DIV); negate remainder if sign(rs1) (REM); register wb_data and wb_rd, pulse wb_en; go to IDLE.
- wb_en forced 0 when rd==0; state sequence unchanged.
- flush: any state -> IDLE, no wb_en, busy low next cycle. flush wins over start in the same cycle.
- busy = (state != IDLE).

## Timing
- Reset: state IDLE, busy 0, wb_en 0, wb_rd 0, wb_data 0, count 0; reset mid-operation drops the operation with no writeback.
- Normal latency: start edge E0; steps on E1..E32; FIX on E33; wb_en high for exactly the cycle after E33.
- Short path: wb_en high for the cycle after E1.
- busy high from after E0 through E33 inclusive; low in the wb_en cycle, so a new start is accepted in that cycle (back-to-back with no bubble).
- wb_rd/wb_data hold their value until the next writeback; only wb_en is pulsed.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared definitions header: op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU), XLEN=32, register index width 5, state encodings.
- One natural sub-module: div_step, combinational single restoring iteration (remainder, quotient, divisor in; next remainder, next quotient out). Remainder of control stays in div_unit.

## Test plan
- DIVU 100/7, rd=3 -> wb_en at cycle 34, wb_rd=3, wb_data=14; REMU same operands -> 2.
- DIV 0xFFFFFF9C (-100)/7 -> 0xFFFFFFF2 (-14); REM -> 0xFFFFFFFE (-2); REM 100/-7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each with wb_en one cycle after start.
- Back-to-back: second start in the wb_en cycle of the first -> accepted; second wb_en exactly 34 cycles later; start while busy -> ignored.
- flush at cycle 10 -> busy low next cycle, no wb_en; rst_n low at cycle 20 -> all outputs 0 immediately.
- rd=0, DIVU 9/3 -> full latency, busy profile identical, wb_en never asserted.
